// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage MIPS pipe: tracks in-flight destinations beyond ID,
// arbitrates dmem/redirect/RAW/imem stalls and drives every latch enable, flush and the PC enable.
module hazard_scoreboard #(
  parameter int DEPTH    = 2,
  parameter int FWD_EN   = 0,
  parameter int BR_STAGE = 3,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_wr_en,
  input  logic [4:0]       id_dest,
  input  logic             id_is_load,
  input  logic             redirect,
  input  logic             ihit,
  input  logic             dmem_req,
  input  logic             dhit,
  output logic             pc_en,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic [1:0]       stall_cause,
  output logic [CNT_W-1:0] stall_cnt
);

  logic       slot_v_r    [DEPTH];
  logic       slot_wr_r   [DEPTH];
  logic       slot_load_r [DEPTH];
  logic [4:0] slot_dest_r [DEPTH];
  logic       any_hit_s;
  logic       data_haz_s;
  logic       dwait_s;
  logic       iwait_s;
  logic [CNT_W-1:0] stall_cnt_r;

  // Register $0 is hard-wired, so a write to it is tracked but can never create a dependence.
  function automatic logic src_hit(input logic uses, input logic [4:0] src,
                                   input logic v, input logic wr, input logic [4:0] dest);
    return uses && (src != 5'd0) && v && wr && (src == dest);
  endfunction

  assign dwait_s   = dmem_req & ~dhit;
  assign iwait_s   = ~ihit;
  assign stall_cnt = stall_cnt_r;

  // RAW detection against the shadow; with forwarding only a load sitting in EX can stall.
  always_comb begin
    any_hit_s = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      any_hit_s = any_hit_s |
                  (((FWD_EN == 0) || ((k == 0) && slot_load_r[k])) &&
                   (src_hit(id_uses_rs, id_rs, slot_v_r[k], slot_wr_r[k], slot_dest_r[k]) ||
                    src_hit(id_uses_rt, id_rt, slot_v_r[k], slot_wr_r[k], slot_dest_r[k])));
    end
    data_haz_s = id_valid & any_hit_s;
  end

  // Priority arbitration of pipe control: dmem wait, redirect, data hazard, imem wait.
  always_comb begin
    pc_en       = 1'b1;
    en_ifid     = 1'b1;
    en_idex     = 1'b1;
    en_exmem    = 1'b1;
    en_memwb    = 1'b1;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    stall_cause = 2'd0;
    if (!nRST) begin
      pc_en       = 1'b0;
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
    end else if (dwait_s) begin
      pc_en       = 1'b0;
      en_ifid     = 1'b0;
      en_idex     = 1'b0;
      en_exmem    = 1'b0;
      en_memwb    = 1'b0;
      stall_cause = 2'd2;
    end else if (redirect) begin
      flush_ifid  = (BR_STAGE >= 1);
      flush_idex  = (BR_STAGE >= 2);
      flush_exmem = (BR_STAGE == 3);
    end else if (data_haz_s) begin
      pc_en       = 1'b0;
      en_ifid     = 1'b0;
      flush_idex  = 1'b1;
      stall_cause = 2'd1;
    end else if (iwait_s) begin
      pc_en       = 1'b0;
      flush_ifid  = 1'b1;
      stall_cause = 2'd3;
    end else begin
      stall_cause = 2'd0;
    end
  end

  // Shadow shift: ID enters slot 0 unless bubbled; the whole shadow freezes on dmem wait.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_v_r[k]    <= 1'b0;
        slot_wr_r[k]   <= 1'b0;
        slot_load_r[k] <= 1'b0;
        slot_dest_r[k] <= 5'd0;
      end
    end else if (!dwait_s) begin
      slot_v_r[0]    <= id_valid   & ~flush_idex;
      slot_wr_r[0]   <= id_wr_en   & ~flush_idex;
      slot_load_r[0] <= id_is_load & ~flush_idex;
      slot_dest_r[0] <= flush_idex ? 5'd0 : id_dest;
      for (int k = 1; k < DEPTH; k++) begin
        if ((k == 1) && flush_exmem) begin
          slot_v_r[k]    <= 1'b0;
          slot_wr_r[k]   <= 1'b0;
          slot_load_r[k] <= 1'b0;
          slot_dest_r[k] <= 5'd0;
        end else begin
          slot_v_r[k]    <= slot_v_r[k-1];
          slot_wr_r[k]   <= slot_wr_r[k-1];
          slot_load_r[k] <= slot_load_r[k-1];
          slot_dest_r[k] <= slot_dest_r[k-1];
        end
      end
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (!pc_en && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end
  end

endmodule
